mult16_rr_arbiter: RTL

- Shares one combinational 16x16 signed Booth-4/Wallace multiplier between two requesters.
- Uses a valid/ready request channel and a valid/ready response channel per requester.
- Registers the operands, drives them to the shared multiplier, waits a programmable settle time, then captures the product and returns it to the granted requester.
- Sits between the client logic and the multiplier array; it is the only driver of the multiplier operand inputs.

---
 rtl/mult16_rr_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mult16_rr_arbiter.sv
// Round-robin arbiter sharing one combinational 16x16 signed multiplier between two requesters.
// Latency: request handshake at cycle T -> resp_valid at T+MULT_LAT+1; one transaction in flight.
// Backpressure: req ready only in IDLE; response held stable until the owner's resp_ready.
//
// Ports:
//   sys_clk, sys_rst_n            clock, async active-low reset
//   req{0,1}_valid/ready/a/b      operand request channel per requester
//   resp{0,1}_valid/ready/p       product response channel per requester
//   mult_a, mult_b, mult_p        operands to / product from the shared multiplier
//   busy                          transaction in flight (CALC or RESP)
module mult16_rr_arbiter #(
  parameter int MULT_LAT = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_p,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_p,
  output logic [15:0] mult_a,
  output logic [15:0] mult_b,
  input  logic [31:0] mult_p,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter is 2 bits wide, enough for MULT_LAT up to 4.
  localparam logic [1:0] CNT_MAX = 2'(MULT_LAT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [31:0] result;
  logic        owner;
  logic        last_grant;
  logic [1:0]  cnt;

  logic        grant_sel;
  logic        req_hs;
  logic        calc_done;
  logic        resp_take;

  // On a tie the requester that did not win last time gets the grant.
  assign grant_sel = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req_hs    = (state == IDLE) && (req0_valid || req1_valid);
  assign calc_done = (state == CALC) && (cnt == CNT_MAX);
  // Only the owner's resp_ready can retire the response.
  assign resp_take = (state == RESP) && (owner ? resp1_ready : resp0_ready);

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_hs)    state_nxt = CALC;
      CALC:    if (calc_done) state_nxt = RESP;
      RESP:    if (resp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid && !grant_sel;
        req1_ready = req1_valid &&  grant_sel;
      end
      CALC: begin
        busy = 1'b1;
      end
      RESP: begin
        busy        = 1'b1;
        resp0_valid = !owner;
        resp1_valid =  owner;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, settle counter, product capture, arbitration pointer.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      op_a       <= 16'd0;
      op_b       <= 16'd0;
      result     <= 32'd0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 2'd0;
    end else begin
      if (req_hs) begin
        op_a       <= grant_sel ? req1_a : req0_a;
        op_b       <= grant_sel ? req1_b : req0_b;
        owner      <= grant_sel;
        last_grant <= grant_sel;
        cnt        <= 2'd0;
      end else if (state == CALC) begin
        cnt <= cnt + 2'd1;
        if (calc_done) begin
          result <= mult_p;
        end
      end
    end
  end

  assign mult_a  = op_a;
  assign mult_b  = op_b;
  assign resp0_p = result;
  assign resp1_p = result;

endmodule
